// File: rtl/apb_master.sv
// apb_master: turns single user commands into APB3 SETUP/ACCESS transfers
// with a bounded ACCESS wait window and a one-cycle response pulse.
// Latency: accept in cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid in
// cycle 3 for a zero-wait slave; every wait state adds one cycle.
// Backpressure: cmd_ready is high in IDLE and on the final ACCESS cycle,
// so a held cmd_valid chains transfers with no idle cycle between them.
//
// Ports:
//   pclk, preset_n                   clock; asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/cmd_addr/cmd_wdata     command payload
//   rsp_valid/rsp_rdata/rsp_error/rsp_timeout   completion report
//   psel/penable/pwrite/paddr/pwdata APB requester outputs
//   pready/pslverr/prdata            APB completer inputs
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15   // legal range 1..255
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB side
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       xfer_done;   // completer answered this cycle
  logic       xfer_tmo;    // wait budget exhausted this cycle
  logic       accept;

  // Completion wins over timeout: pready=1 on the last allowed wait cycle
  // still finishes the transfer normally.
  always_comb begin
    xfer_done = 1'b0;
    xfer_tmo  = 1'b0;
    if (state_q == ACCESS) begin
      xfer_done = pready;
      xfer_tmo  = !pready && (wait_cnt == TIMEOUT_CNT);
    end
  end

  // Next-state and control outputs. cmd_ready is deliberately combinational
  // on pready so the next command can be taken on the completion edge.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (xfer_done || xfer_tmo) begin
          cmd_ready = 1'b1;
          state_d   = cmd_valid ? SETUP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      state_q     <= IDLE;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      wait_cnt    <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;

      // Address/data only move on an accepted command, so they stay stable
      // through SETUP/ACCESS and keep the last values while idle.
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end

      // SETUP always precedes ACCESS, so clearing here zeroes the count on
      // ACCESS entry; it never passes TIMEOUT because that aborts first.
      if (state_q == SETUP) begin
        wait_cnt <= 8'd0;
      end else if ((state_q == ACCESS) && !pready && !xfer_tmo) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      rsp_valid <= xfer_done || xfer_tmo;
      if (xfer_done) begin
        rsp_error   <= pslverr;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= pwrite ? '0 : prdata;
      end else if (xfer_tmo) begin
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized plus directed transfers against a timeline
// model of apb_master (per-command latency, window and response values).
// Checks run on the falling edge; inputs are driven there as well.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int MAX_CYC = 20000;

  logic          pclk;
  logic          preset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One command: waits = ACCESS cycles with pready low before it rises
  // (anything above TO means the completer never answers). rst_k >= 0 pulses
  // reset on that ACCESS cycle index of this command.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] rdata;
    int            gap;
    int            rst_k;
  } txn_t;

  typedef struct {
    int            cyc;
    logic          err;
    logic          to;
    logic [DW-1:0] rdata;
  } rsp_t;

  txn_t txq[$];
  rsp_t rq[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int waits, input logic se, input logic [DW-1:0] rd,
                              input int gap, input int rst_k);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.waits = waits; t.slverr = se;
    t.rdata = rd; t.gap = gap; t.rst_k = rst_k;
    return t;
  endfunction

  // Model state: the command currently on the bus and the last values the
  // DUT is expected to be holding.
  bit            have;
  int            acc;
  int            idx;
  txn_t          cur;
  logic [AW-1:0] last_addr;
  logic          last_wr;
  logic [DW-1:0] last_wdata;
  logic          last_err;
  logic          last_to;
  logic [DW-1:0] last_rdata;
  int            gap_cnt;
  int            n;

  task automatic clear_model();
    have = 0; acc = 0; idx = 0;
    last_addr = '0; last_wr = 1'b0; last_wdata = '0;
    last_err = 1'b0; last_to = 1'b0; last_rdata = '0;
    rq.delete();
  endtask

  initial begin
    bit   exp_psel, exp_pen, ready_exp, vld, cmpl, timed_out, rsp_now;
    int   k;
    txn_t t;
    rsp_t r;

    preset_n = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    clear_model();

    repeat (3) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", {rsp_error, rsp_timeout}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // Directed: basic write, waited read, back-to-back writes, timeout,
    // completion on the last legal wait, one past it, slave error, reset.
    txq.push_back(mk(1, 8'h12, 32'hDEADBEEF, 0, 0, 32'h0, 0, -1));
    txq.push_back(mk(0, 8'h34, 32'h0, 3, 0, 32'hCAFEF00D, 2, -1));
    txq.push_back(mk(1, 8'h40, 32'h11111111, 0, 0, 32'h0, 2, -1));
    txq.push_back(mk(1, 8'h44, 32'h22222222, 0, 0, 32'h0, 0, -1));
    txq.push_back(mk(0, 8'h50, 32'h0, 1000, 0, 32'h55AA55AA, 0, -1));
    txq.push_back(mk(0, 8'h54, 32'h0, TO, 0, 32'h0BADF00D, 3, -1));
    txq.push_back(mk(0, 8'h58, 32'h0, TO + 1, 0, 32'h12345678, 2, -1));
    txq.push_back(mk(1, 8'h60, 32'h33333333, 2, 1, 32'h0, 3, -1));
    txq.push_back(mk(0, 8'h64, 32'h0, 10, 0, 32'h77777777, 1, 2));
    txq.push_back(mk(1, 8'h68, 32'h44444444, 0, 0, 32'h0, 0, -1));
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(0, 4);
      txq.push_back(mk($urandom_range(0, 1) == 1, 8'($urandom), $urandom, w,
                       $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2), -1));
    end
    gap_cnt = txq[0].gap;

    @(negedge pclk);
    preset_n = 1'b0;
    n = 0;
    while (1) begin
      // A reset scheduled inside this command's ACCESS phase.
      if (have && n >= acc + 2 && n <= acc + 2 + idx && cur.rst_k >= 0 &&
          (n - acc - 2) == cur.rst_k) begin
        preset_n = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        clear_model();
        @(negedge pclk); n++;
        @(negedge pclk); n++;
        chk("mid_rst_no_rsp", rsp_valid, 0);
        preset_n = 1'b0;
      end

      exp_psel = have && n >= acc + 1 && n <= acc + 2 + idx;
      exp_pen  = have && n >= acc + 2 && n <= acc + 2 + idx;
      k = n - acc - 2;
      ready_exp = !(have && n >= acc + 1 && n <= acc + 1 + idx);

      chk("psel", psel, exp_psel);
      chk("penable", penable, exp_pen);
      chk("paddr", paddr, last_addr);
      chk("pwrite", pwrite, last_wr);
      chk("pwdata", pwdata, last_wdata);

      rsp_now = (rq.size() > 0) && (rq[0].cyc == n);
      chk("rsp_valid", rsp_valid, rsp_now);
      if (rsp_now) begin
        r = rq.pop_front();
        last_err = r.err; last_to = r.to; last_rdata = r.rdata;
      end
      chk("rsp_error", rsp_error, last_err);
      chk("rsp_timeout", rsp_timeout, last_to);
      chk("rsp_rdata", rsp_rdata, last_rdata);

      // Completer: pready only rises on the chosen ACCESS cycle; pslverr and
      // prdata are noise everywhere else, and pready is noise outside ACCESS.
      if (exp_pen) begin
        cmpl = (cur.waits <= TO) && (k == cur.waits);
        pready = cmpl;
        pslverr = cmpl ? cur.slverr : 1'($urandom);
        prdata = (cmpl && !cur.wr) ? cur.rdata : $urandom;
      end else begin
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
      end

      // Command side: the real payload only while the DUT should be ready;
      // junk otherwise to show it is ignored.
      vld = (txq.size() > 0) && (gap_cnt == 0);
      cmd_valid = vld;
      if (vld && ready_exp) begin
        cmd_write = txq[0].wr; cmd_addr = txq[0].addr; cmd_wdata = txq[0].wdata;
      end else begin
        cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
      end
      if (txq.size() > 0 && gap_cnt > 0) gap_cnt--;

      #1;
      chk("cmd_ready", cmd_ready, ready_exp);

      if (vld && ready_exp) begin
        t = txq.pop_front();
        timed_out = t.waits > TO;
        idx = timed_out ? TO : t.waits;
        if (t.rst_k < 0) begin
          r.cyc = n + 3 + idx;
          r.err = timed_out ? 1'b1 : t.slverr;
          r.to = timed_out;
          r.rdata = (timed_out || t.wr) ? '0 : t.rdata;
          rq.push_back(r);
        end
        cur = t; have = 1; acc = n;
        last_addr = t.addr; last_wr = t.wr; last_wdata = t.wdata;
        if (txq.size() > 0) gap_cnt = txq[0].gap;
      end

      if (txq.size() == 0 && rq.size() == 0 && !(have && n <= acc + 3 + idx)) break;
      if (n >= MAX_CYC) begin
        chk("cycle_budget", 1, 0);
        break;
      end
      @(negedge pclk);
      n++;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 ADDR_WIDTH, 8, address width of cmd_addr/paddr.
REQ-002 DATA_WIDTH, 32, data width of write/read data paths.
REQ-003 TIMEOUT, 15, max ACCESS wait states before abort; legal range 1..255.
REQ-004 pclk  input  1  clock; all state changes on rising edge.
REQ-005 preset_n  input  1  reset, asynchronous, active-high; clock pclk.
REQ-006 cmd_valid  input  1  user requests a transfer.
REQ-007 cmd_ready  output  1  command accepted on edge where cmd_valid&cmd_ready.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes, errors, timeouts.
REQ-013 rsp_error  output  1  pslverr sampled at completion, or timeout.
REQ-014 rsp_timeout  output  1  completion caused by timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_WIDTH; pwdata  output  DATA_WIDTH.
REQ-017 pready, pslverr  input  1 each; prdata  input  DATA_WIDTH.

Function
REQ-018 States IDLE, SETUP, ACCESS; encoding free.
REQ-019 cmd_ready SHALL be combinational: high in IDLE, and in ACCESS on the completion cycle (pready=1 or wait count = TIMEOUT); low otherwise.
REQ-020 On accept, cmd_addr/cmd_write/cmd_wdata registered onto paddr/pwrite/pwdata; next state SETUP.
REQ-021 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS unconditionally.
REQ-022 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable from SETUP until completion.
REQ-023 8-bit wait counter cleared on ACCESS entry; +1 per ACCESS cycle with pready=0.
REQ-024 Completion when pready=1 in ACCESS: next cycle rsp_valid=1, rsp_error=pslverr, rsp_timeout=0, rsp_rdata=prdata if read else 0.
REQ-025 Timeout when pready=0 and counter = TIMEOUT: transfer aborted, next cycle rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 After completion/timeout: cmd_valid=1 -> accept, go SETUP (psel stays 1, penable drops 0); else IDLE with psel=penable=0.
REQ-027 Zero-wait latency: accept cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3; each wait state adds one cycle.
REQ-028 pslverr and prdata ignored except on completion cycle; pready ignored outside ACCESS.
REQ-029 rsp_valid high exactly one cycle per accepted command; rsp_* hold last values when rsp_valid=0.
REQ-030 In IDLE paddr/pwrite/pwdata hold last transfer values.
REQ-031 cmd_* changes while cmd_ready=0 SHALL not affect the in-flight transfer.

Reset
REQ-032 preset_n=1 immediately forces IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, counter=0.
REQ-033 Reset mid-transfer aborts without rsp_valid; first command after release accepted in the first cycle with preset_n=0.

Verification
REQ-034 Write 0x12/0xDEADBEEF, pready=1 always -> psel rises cycle 1, penable cycle 2, rsp_valid cycle 3, rsp_error=0, rsp_rdata=0.
REQ-035 Read 0x34, pready low 3 ACCESS cycles, prdata=0xCAFEF00D at completion -> paddr stable throughout, rsp_valid cycle 6, rsp_rdata=0xCAFEF00D.
REQ-036 Two back-to-back writes, cmd_valid held -> psel continuously 1, penable 0 for one cycle between, two rsp_valid pulses 2 cycles apart.
REQ-037 Read, pready never asserted, TIMEOUT=15 -> abort after 15 wait cycles, rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0, psel=0.
REQ-038 Write with pslverr=1 and pready=1 -> rsp_error=1, rsp_timeout=0; pslverr=1 while pready=0 does not end the transfer.
REQ-039 preset_n pulsed during ACCESS -> psel/penable 0 at once, no rsp_valid; next command completes normally.
